gpio_in_conditioner: RTL and testbench



---
 rtl/gpio_in_cond_pkg.sv | 12 +
 rtl/gpio_in_conditioner_if.sv | 24 ++
 rtl/gpio_debounce_bit.sv | 69 ++++++
 rtl/gpio_in_conditioner.sv | 65 ++++++
 tb/tb_gpio_in_conditioner.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_in_cond_pkg.sv
// Shared defaults and vector types for the GPIO input conditioning slice.
// Optional glitch counter is enabled by defining GPIO_IN_COND_GLITCH_CNT_EN.
package gpio_in_cond_pkg;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEBOUNCE_W  = 16;

  typedef logic [DEF_DEBOUNCE_W-1:0] dbnc_cnt_t;
  typedef logic [DEF_WIDTH-1:0]      gpio_vec_t;

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Pin/config/output bundle between the conditioner and its surroundings.
// glitch_cnt_o exists only when GPIO_IN_COND_GLITCH_CNT_EN is defined.
import gpio_in_cond_pkg::*;

interface gpio_in_conditioner_if #(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEBOUNCE_W = DEF_DEBOUNCE_W
);
  logic [WIDTH-1:0]      pins_i;
  logic [DEBOUNCE_W-1:0] cfg_thresh_i;
  logic [WIDTH-1:0]      pio_o;
  logic [WIDTH-1:0]      rise_o;
  logic [WIDTH-1:0]      fall_o;
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
  logic [31:0]           glitch_cnt_o;

  modport slave  (input pins_i, cfg_thresh_i, output pio_o, rise_o, fall_o, glitch_cnt_o);
  modport master (output pins_i, cfg_thresh_i, input pio_o, rise_o, fall_o, glitch_cnt_o);
`else
  modport slave  (input pins_i, cfg_thresh_i, output pio_o, rise_o, fall_o);
  modport master (output pins_i, cfg_thresh_i, input pio_o, rise_o, fall_o);
`endif

endinterface

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: flop synchroniser, threshold debounce counter and edge pulses.
// glitch_o port is present only when GPIO_IN_COND_GLITCH_CNT_EN is defined.
import gpio_in_cond_pkg::*;

module gpio_debounce_bit #(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pin_i,
  input  logic [DEBOUNCE_W-1:0] thresh_i,
  output logic                  pio_o,
  output logic                  rise_o,
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
  output logic                  fall_o,
  output logic                  glitch_o
`else
  output logic                  fall_o
`endif
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;
  logic                   pio_q, pio_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s, differ, commit;
  logic [DEBOUNCE_W:0]    cnt_inc;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
    s       = sync_q[SYNC_STAGES-1];
    differ  = s ^ pio_q;
    // Extra MSB keeps cnt+1 exact so the threshold compare cannot wrap.
    cnt_inc = {1'b0, cnt_q} + {{DEBOUNCE_W{1'b0}}, 1'b1};
    commit  = differ && ((thresh_i == '0) || (cnt_inc >= {1'b0, thresh_i}));
    pio_d   = commit ? s : pio_q;
    cnt_d   = (differ && !commit) ? cnt_inc[DEBOUNCE_W-1:0] : '0;
    rise_d  = commit & s;
    fall_d  = commit & ~s;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      pio_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      pio_q  <= pio_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign pio_o  = pio_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

`ifdef GPIO_IN_COND_GLITCH_CNT_EN
  // A pending count abandoned because the level returned is a rejected glitch.
  assign glitch_o = !differ && (cnt_q != '0);
`endif

endmodule

// File: rtl/gpio_in_conditioner.sv
// Per-bit synchronise + debounce of raw GPIO pins feeding the GPIO slave pio_i.
// Define GPIO_IN_COND_GLITCH_CNT_EN to add the saturating glitch_cnt_o counter.
import gpio_in_cond_pkg::*;

module gpio_in_conditioner #(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  gpio_in_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] pio_vec, rise_vec, fall_vec;
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
  logic [WIDTH-1:0] glitch_vec;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W)
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_i    (bus.pins_i[i]),
      .thresh_i (bus.cfg_thresh_i),
      .pio_o    (pio_vec[i]),
      .rise_o   (rise_vec[i]),
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
      .fall_o   (fall_vec[i]),
      .glitch_o (glitch_vec[i])
`else
      .fall_o   (fall_vec[i])
`endif
    );
  end

  assign bus.pio_o  = pio_vec;
  assign bus.rise_o = rise_vec;
  assign bus.fall_o = fall_vec;

`ifdef GPIO_IN_COND_GLITCH_CNT_EN
  logic [31:0] glitch_cnt_q, glitch_cnt_d;

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if ((|glitch_vec) && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign bus.glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Bench for gpio_in_conditioner: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the debounce rules.
import gpio_in_cond_pkg::*;

module tb_gpio_in_conditioner;

  localparam int unsigned W  = 32;
  localparam int unsigned SS = 2;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.WIDTH(W), .DEBOUNCE_W(DW)) bus ();

  gpio_in_conditioner #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .DEBOUNCE_W  (DW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pins delayed SS edges, then a run of consecutive
  // disagreeing cycles per bit that commits once it reaches max(T,1).
  gpio_vec_t   hist[$];
  gpio_vec_t   m_pio, m_rise, m_fall;
  int unsigned run[W];
  longint unsigned m_glitch;

  initial begin
    m_pio = '0; m_rise = '0; m_fall = '0; m_glitch = 0;
    for (int i = 0; i < W; i++) run[i] = 0;
  end

  always @(posedge clk) begin
    gpio_vec_t   s, nr, nf;
    int unsigned thr;
    bit          gl;
    if (!reset_n) begin
      hist.delete();
      for (int k = 0; k < SS; k++) hist.push_back('0);
      m_pio = '0; m_rise = '0; m_fall = '0; m_glitch = 0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      s = hist.pop_front();
      hist.push_back(bus.pins_i);
      thr = (bus.cfg_thresh_i == 0) ? 1 : int'(bus.cfg_thresh_i);
      nr = '0; nf = '0; gl = 0;
      for (int i = 0; i < W; i++) begin
        if (s[i] == m_pio[i]) begin
          if (run[i] != 0) gl = 1;
          run[i] = 0;
        end else begin
          run[i] = run[i] + 1;
          if (run[i] >= thr) begin
            m_pio[i] = s[i];
            if (s[i]) nr[i] = 1'b1; else nf[i] = 1'b1;
            run[i] = 0;
          end
        end
      end
      m_rise = nr;
      m_fall = nf;
      if (gl && m_glitch < 64'hFFFF_FFFF) m_glitch = m_glitch + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.pins_i = '1;
    bus.cfg_thresh_i = '0;
    repeat (3) step();
    if ({bus.pio_o, bus.rise_o, bus.fall_o} !== {W*3{1'b0}}) begin
      errors++;
      $display("FAIL reset_hold pio=%h rise=%h fall=%h required all 0", bus.pio_o, bus.rise_o, bus.fall_o);
    end
    checks++;
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      gpio_vec_t ep, er;
      step();
      ep = (k >= 3) ? '1 : '0;
      er = (k == 3) ? '1 : '0;
      if (bus.pio_o !== ep || bus.rise_o !== er || bus.fall_o !== '0) begin
        errors++;
        $display("FAIL reset_release k=%0d pio=%h/%h rise=%h/%h fall=%h/0", k, bus.pio_o, ep, bus.rise_o, er, bus.fall_o);
      end
      checks++;
    end
  endtask

  task automatic test_commit();
    bus.cfg_thresh_i = '0;
    bus.pins_i = '0;
    repeat (4) step();
    bus.cfg_thresh_i = 16'd4;
    bus.pins_i = 32'h1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (bus.pio_o[0] !== (k >= 6) || bus.rise_o[0] !== (k == 6) || bus.fall_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL commit k=%0d pio0=%b rise0=%b fall0=%b required pio0=%b rise0=%b", k, bus.pio_o[0], bus.rise_o[0], bus.fall_o[0], k >= 6, k == 6);
      end
      checks++;
      if ({bus.pio_o, bus.rise_o, bus.fall_o} !== {m_pio, m_rise, m_fall}) begin
        errors++;
        $display("FAIL commit_model k=%0d pio=%h/%h rise=%h/%h fall=%h/%h", k, bus.pio_o, m_pio, bus.rise_o, m_rise, bus.fall_o, m_fall);
      end
      checks++;
    end
  endtask

  task automatic test_glitch();
    longint unsigned g0;
    bus.cfg_thresh_i = '0;
    bus.pins_i = '0;
    repeat (4) step();
    bus.cfg_thresh_i = 16'd4;
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
    g0 = longint'(bus.glitch_cnt_o);
`else
    g0 = m_glitch;
`endif
    bus.pins_i = 32'h8;
    repeat (3) step();
    bus.pins_i = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (bus.pio_o[3] !== 1'b0 || bus.rise_o[3] !== 1'b0 || bus.fall_o[3] !== 1'b0) begin
        errors++;
        $display("FAIL glitch k=%0d pio3=%b rise3=%b fall3=%b required 0 0 0", k, bus.pio_o[3], bus.rise_o[3], bus.fall_o[3]);
      end
      checks++;
    end
    if (m_glitch != g0 + 1) begin
      errors++;
      $display("FAIL glitch_model_count model=%0d required %0d", m_glitch, g0 + 1);
    end
    checks++;
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
    if (longint'(bus.glitch_cnt_o) != g0 + 1) begin
      errors++;
      $display("FAIL glitch_cnt got=%0d required %0d", bus.glitch_cnt_o, g0 + 1);
    end
    checks++;
`endif
  endtask

  task automatic test_multi();
    bus.cfg_thresh_i = '0;
    bus.pins_i = 32'h0000_00FF;
    repeat (4) step();
    bus.cfg_thresh_i = 16'd2;
    bus.pins_i = 32'h0000_0F0F;
    for (int k = 1; k <= 5; k++) begin
      gpio_vec_t ep, er, ef;
      step();
      ep = (k >= 4) ? 32'h0000_0F0F : 32'h0000_00FF;
      er = (k == 4) ? 32'h0000_0F00 : '0;
      ef = (k == 4) ? 32'h0000_00F0 : '0;
      if (bus.pio_o !== ep || bus.rise_o !== er || bus.fall_o !== ef) begin
        errors++;
        $display("FAIL multi k=%0d pio=%h/%h rise=%h/%h fall=%h/%h", k, bus.pio_o, ep, bus.rise_o, er, bus.fall_o, ef);
      end
      checks++;
    end
  endtask

  task automatic test_thresh_change();
    bus.cfg_thresh_i = '0;
    bus.pins_i = '0;
    repeat (4) step();
    bus.cfg_thresh_i = 16'd100;
    bus.pins_i = 32'h20;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.pio_o[5] !== 1'b0 || bus.rise_o[5] !== 1'b0) begin
        errors++;
        $display("FAIL thresh_wait k=%0d pio5=%b rise5=%b required 0 0", k, bus.pio_o[5], bus.rise_o[5]);
      end
      checks++;
    end
    bus.cfg_thresh_i = 16'd5;
    step();
    if (bus.pio_o[5] !== 1'b1 || bus.rise_o[5] !== 1'b1) begin
      errors++;
      $display("FAIL thresh_lower pio5=%b rise5=%b required 1 1", bus.pio_o[5], bus.rise_o[5]);
    end
    checks++;
    step();
    if (bus.rise_o[5] !== 1'b0 || bus.pio_o[5] !== 1'b1) begin
      errors++;
      $display("FAIL thresh_pulse_width pio5=%b rise5=%b required 1 0", bus.pio_o[5], bus.rise_o[5]);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int found;
    bus.cfg_thresh_i = '0;
    bus.pins_i = 32'h80;
    repeat (4) step();
    bus.cfg_thresh_i = 16'd8;
    bus.pins_i = '0;
    repeat (7) step();
    reset_n = 1'b0;
    step();
    if (bus.pio_o !== '0 || bus.fall_o !== '0 || bus.rise_o !== '0) begin
      errors++;
      $display("FAIL reset_mid pio=%h rise=%h fall=%h required all 0", bus.pio_o, bus.rise_o, bus.fall_o);
    end
    checks++;
    reset_n = 1'b1;
    bus.pins_i = 32'h80;
    found = -1;
    for (int k = 1; k <= 20 && found < 0; k++) begin
      step();
      if ({bus.pio_o, bus.rise_o, bus.fall_o} !== {m_pio, m_rise, m_fall}) begin
        errors++;
        $display("FAIL reset_mid_model k=%0d pio=%h/%h rise=%h/%h fall=%h/%h", k, bus.pio_o, m_pio, bus.rise_o, m_rise, bus.fall_o, m_fall);
      end
      checks++;
      if (bus.rise_o[7] === 1'b1) found = k;
    end
    if (found != 10) begin
      errors++;
      $display("FAIL reset_mid_restart rise7 at cycle %0d required 10 (-1 = none within bound)", found);
    end
    checks++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 63) == 0) bus.cfg_thresh_i = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) bus.pins_i = bus.pins_i ^ ($urandom & $urandom & $urandom);
      step();
      if ({bus.pio_o, bus.rise_o, bus.fall_o} !== {m_pio, m_rise, m_fall}) begin
        errors++;
        $display("FAIL random c=%0d pio=%h/%h rise=%h/%h fall=%h/%h", c, bus.pio_o, m_pio, bus.rise_o, m_rise, bus.fall_o, m_fall);
      end
      checks++;
`ifdef GPIO_IN_COND_GLITCH_CNT_EN
      if (longint'(bus.glitch_cnt_o) != m_glitch) begin
        errors++;
        $display("FAIL random_glitch_cnt c=%0d got=%0d required %0d", c, bus.glitch_cnt_o, m_glitch);
      end
      checks++;
`endif
    end
    reset_n = 1'b1;
  endtask

  initial begin
    bus.pins_i = '0;
    bus.cfg_thresh_i = '0;
    test_reset();
    test_commit();
    test_glitch();
    test_multi();
    test_thresh_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
